// File: rtl/mips_trace_buffer_pkg.sv
// Shared definitions for the MIPS trace buffer: state encoding, entry layout and entry width.
// The entry grows by TS_W bits when TRACE_TIMESTAMP_EN is defined.
package mips_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int ADDR_LSB  = 0;
    localparam int DATA_LSB  = 32;
    localparam int TS_LSB    = 64;
    localparam int PAYLOAD_W = 64;

`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    function automatic int entry_w(input int ts_w);
        return PAYLOAD_W + (TS_EN ? ts_w : 0);
    endfunction

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Capture-side and readout-side signals of the trace buffer.
// The slave modport is the buffer; the master modport is the core/host side driving it.
interface mips_trace_buffer_if #(
    parameter int AW   = 6,
    parameter int TS_W = 16
);
    logic [31:0]     ADDRESS;
    logic [31:0]     DATA;
    logic            CAP_EN;
    logic            ARM;
    logic [31:0]     TRIG_ADDR;
    logic            FORCE_TRIG;
    logic            RD_VALID;
    logic            RD_READY;
    logic [31:0]     RD_ADDR;
    logic [31:0]     RD_DATA;
    logic [TS_W-1:0] RD_TS;
    logic [1:0]      STATE;
    logic [AW:0]     FILL;
    logic            TRIGGERED;

    modport master (
        output ADDRESS, DATA, CAP_EN, ARM, TRIG_ADDR, FORCE_TRIG, RD_READY,
        input  RD_VALID, RD_ADDR, RD_DATA, RD_TS, STATE, FILL, TRIGGERED
    );

    modport slave (
        input  ADDRESS, DATA, CAP_EN, ARM, TRIG_ADDR, FORCE_TRIG, RD_READY,
        output RD_VALID, RD_ADDR, RD_DATA, RD_TS, STATE, FILL, TRIGGERED
    );
endinterface

// File: rtl/mips_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x W array, one synchronous write port, one asynchronous read port.
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int W     = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; every location is written before the read pointer can reach it.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/mips_trace_buffer.sv
// Trace capture of {PC, Result} with PC-match trigger, post-trigger window and oldest-first readout.
// Define TRACE_TIMESTAMP_EN to store a free-running timestamp with each entry.
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int AW        = 6,
    parameter int POST_TRIG = 16,
    parameter int TS_W      = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    mips_trace_buffer_if.slave bus
);
    localparam int            EW      = entry_w(TS_W);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_C  = AW'(POST_TRIG);

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] postcnt_q, postcnt_d;
    logic [AW:0]   fill_q, fill_d;
    logic          trig_q, trig_d;
    logic          we;
    logic          hit;
    logic          rd_fire;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    assign hit     = bus.FORCE_TRIG | (bus.ADDRESS == bus.TRIG_ADDR);
    assign rd_fire = bus.RD_VALID & bus.RD_READY;

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        postcnt_d = postcnt_q;
        fill_d    = fill_q;
        trig_d    = trig_q;
        we        = 1'b0;
        if (bus.ARM) begin
            state_d   = ST_ARMED;
            wptr_d    = '0;
            rptr_d    = '0;
            postcnt_d = '0;
            fill_d    = '0;
            trig_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED, ST_POST: begin
                    if (bus.CAP_EN) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + AW'(1);
                        if (fill_q != DEPTH_C) fill_d = fill_q + (AW+1)'(1);
                        if (state_q == ST_ARMED) begin
                            if (hit) begin
                                trig_d = 1'b1;
                                if (POST_TRIG == 0) state_d = ST_DONE;
                                else begin
                                    state_d   = ST_POST;
                                    postcnt_d = POST_C;
                                end
                            end
                        end else begin
                            postcnt_d = postcnt_q - AW'(1);
                            if (postcnt_q == AW'(1)) state_d = ST_DONE;
                        end
                        // Oldest entry sits FILL slots behind the write pointer; a full buffer wraps to wptr.
                        if (state_d == ST_DONE) rptr_d = wptr_d - fill_d[AW-1:0];
                    end
                end
                ST_DONE: begin
                    if (fill_q == '0) state_d = ST_IDLE;
                    else if (rd_fire) begin
                        rptr_d = rptr_q + AW'(1);
                        fill_d = fill_q - (AW+1)'(1);
                        if (fill_q == (AW+1)'(1)) state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; RESET is sampled on the clock edge only.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            postcnt_q <= '0;
            fill_q    <= '0;
            trig_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            postcnt_q <= postcnt_d;
            fill_q    <= fill_d;
            trig_q    <= trig_d;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    always_comb ts_d = ts_q + TS_W'(1);

    always_ff @(posedge CLK) begin
        if (!RESET) ts_q <= '0;
        else        ts_q <= ts_d;
    end

    assign wdata  = {ts_q, bus.DATA, bus.ADDRESS};
    assign bus.RD_TS = rdata[TS_LSB +: TS_W];
`else
    assign wdata  = {bus.DATA, bus.ADDRESS};
    assign bus.RD_TS = '0;
`endif

    trace_ram #(.DEPTH(DEPTH), .AW(AW), .W(EW)) u_ram (
        .clk   (CLK),
        .we    (we),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (rptr_q),
        .rdata (rdata)
    );

    assign bus.RD_VALID  = (state_q == ST_DONE) && (fill_q != '0);
    assign bus.RD_ADDR   = rdata[ADDR_LSB +: 32];
    assign bus.RD_DATA   = rdata[DATA_LSB +: 32];
    assign bus.STATE     = state_q;
    assign bus.FILL      = fill_q;
    assign bus.TRIGGERED = trig_q;
endmodule
